cpu_fetch: RTL and testbench



---
 rtl/cpu_fetch.sv | 184 ++++++++++++++++++
 tb/tb_cpu_fetch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : cpu_fetch
// Brief    : klara-rv instruction fetch stage; one word per fetch, 121-bit
//            record with pre-decoded register indices, stops on control flow.
// Revision : 1.0
// ============================================================================
module cpu_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic         i_clock,
  input  logic         i_reset,
  output logic         o_bus_request,
  output logic [31:0]  o_bus_address,
  input  logic         i_bus_ready,
  input  logic [31:0]  i_bus_rdata,
  input  logic         i_busy,
  input  logic         i_pc_valid,
  input  logic [31:0]  i_pc,
  output logic [120:0] o_data,
  output logic         o_fault
);

  localparam logic [6:0] c_OP_LOAD_FP  = 7'h07;
  localparam logic [6:0] c_OP_MISC_MEM = 7'h0f;
  localparam logic [6:0] c_OP_AUIPC    = 7'h17;
  localparam logic [6:0] c_OP_STORE    = 7'h23;
  localparam logic [6:0] c_OP_STORE_FP = 7'h27;
  localparam logic [6:0] c_OP_OP       = 7'h33;
  localparam logic [6:0] c_OP_LUI      = 7'h37;
  localparam logic [6:0] c_OP_FMADD    = 7'h43;
  localparam logic [6:0] c_OP_FMSUB    = 7'h47;
  localparam logic [6:0] c_OP_FNMSUB   = 7'h4b;
  localparam logic [6:0] c_OP_FNMADD   = 7'h4f;
  localparam logic [6:0] c_OP_FP       = 7'h53;
  localparam logic [6:0] c_OP_BRANCH   = 7'h63;
  localparam logic [6:0] c_OP_JALR     = 7'h67;
  localparam logic [6:0] c_OP_JAL      = 7'h6f;
  localparam logic [6:0] c_OP_SYSTEM   = 7'h73;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_WAIT    = 3'd1,
    S_EMIT    = 3'd2,
    S_WAIT_PC = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t         r_state, w_state_next;
  logic [31:0]    r_pc, w_pc_next;
  logic [31:0]    r_instr, w_instr_next;
  logic [120:0]   r_data, w_data_next;
  logic           r_fault, w_fault_next;
  logic           r_request, w_request_next;

  logic [6:0]     w_opcode;
  logic [4:0]     w_funct5;
  logic           w_rs1_used, w_rs2_used, w_r4, w_rd_used, w_control;
  logic           w_rs1_fp, w_rs2_fp, w_rd_fp, w_fp_op;
  logic [5:0]     w_rs1, w_rs2, w_rs3, w_rd;
  logic [31:0]    w_pc_plus4;
  logic           w_illegal;

  assign w_opcode   = r_instr[6:0];
  assign w_funct5   = r_instr[31:27];
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_illegal  = (r_instr[1:0] != 2'b11);

  // Operand format classification from the major opcode
  always_comb begin
    w_rs1_used = 1'b1;
    w_rs2_used = 1'b0;
    w_r4       = 1'b0;
    w_rd_used  = 1'b1;
    w_control  = 1'b0;
    case (w_opcode)
      c_OP_LUI, c_OP_AUIPC: w_rs1_used = 1'b0;
      c_OP_JAL: begin
        w_rs1_used = 1'b0;
        w_control  = 1'b1;
      end
      c_OP_STORE, c_OP_STORE_FP: begin
        w_rs2_used = 1'b1;
        w_rd_used  = 1'b0;
      end
      c_OP_BRANCH: begin
        w_rs2_used = 1'b1;
        w_rd_used  = 1'b0;
        w_control  = 1'b1;
      end
      c_OP_OP, c_OP_FP: w_rs2_used = 1'b1;
      c_OP_FMADD, c_OP_FMSUB, c_OP_FNMSUB, c_OP_FNMADD: begin
        w_rs2_used = 1'b1;
        w_r4       = 1'b1;
      end
      c_OP_JALR, c_OP_SYSTEM, c_OP_MISC_MEM: w_control = 1'b1;
      default: ;
    endcase
  end

  // OP-FP moves/compares/converts touching the integer file clear one bank bit
  assign w_fp_op  = (w_opcode == c_OP_FP);
  assign w_rd_fp  = (w_opcode == c_OP_LOAD_FP) || w_r4 ||
                    (w_fp_op && w_funct5 != 5'h14 && w_funct5 != 5'h18 && w_funct5 != 5'h1c);
  assign w_rs1_fp = w_r4 || (w_fp_op && w_funct5 != 5'h1a && w_funct5 != 5'h1e);
  assign w_rs2_fp = (w_opcode == c_OP_STORE_FP) || w_r4 || w_fp_op;

  assign w_rs1 = w_rs1_used ? {w_rs1_fp, r_instr[19:15]} : 6'd0;
  assign w_rs2 = w_rs2_used ? {w_rs2_fp, r_instr[24:20]} : 6'd0;
  assign w_rs3 = w_r4       ? {1'b1,     r_instr[31:27]} : 6'd0;
  assign w_rd  = w_rd_used  ? {w_rd_fp,  r_instr[11:7]}  : 6'd0;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_instr_next = r_instr;
    w_data_next  = r_data;
    w_fault_next = r_fault;
    case (r_state)
      S_FETCH: w_state_next = S_WAIT;
      S_WAIT: begin
        if (i_bus_ready) begin
          w_instr_next = i_bus_rdata;
          w_state_next = S_EMIT;
        end
      end
      S_EMIT: begin
        if (!i_busy) begin
          w_data_next = {~r_data[120], r_instr, r_pc, w_rs1, w_rs2, w_rs3, w_rd, w_pc_plus4};
          if (w_illegal) begin
            w_fault_next = 1'b1;
            w_state_next = S_HALT;
          end else if (w_control) begin
            w_state_next = S_WAIT_PC;
          end else begin
            w_pc_next    = w_pc_plus4;
            w_state_next = S_FETCH;
          end
        end
      end
      S_WAIT_PC: begin
        if (i_pc_valid) begin
          if (i_pc[1:0] != 2'b00) begin
            w_fault_next = 1'b1;
            w_state_next = S_HALT;
          end else begin
            w_pc_next    = i_pc;
            w_state_next = S_FETCH;
          end
        end
      end
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_FETCH;
    endcase
  end

  // Request is registered from the upcoming state so it never follows inputs
  assign w_request_next = (w_state_next == S_FETCH) || (w_state_next == S_WAIT);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_VECTOR;
      r_instr   <= 32'd0;
      r_data    <= '0;
      r_fault   <= 1'b0;
      r_request <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_instr   <= w_instr_next;
      r_data    <= w_data_next;
      r_fault   <= w_fault_next;
      r_request <= w_request_next;
    end
  end

  assign o_bus_request = r_request;
  assign o_bus_address = r_pc;
  assign o_data        = r_data;
  assign o_fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_cpu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_fetch
// Brief    : Self-checking bench for cpu_fetch: directed steps plus random
//            instruction stream against a program-level reference model.
// Revision : 1.0
// ============================================================================
module tb_cpu_fetch;

  localparam logic [31:0] c_RESET_VECTOR = 32'h0000_0000;

  logic         i_clock;
  logic         i_reset;
  logic         o_bus_request;
  logic [31:0]  o_bus_address;
  logic         i_bus_ready;
  logic [31:0]  i_bus_rdata;
  logic         i_busy;
  logic         i_pc_valid;
  logic [31:0]  i_pc;
  logic [120:0] o_data;
  logic         o_fault;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0]  m_pc;
  logic         m_tag;
  logic [120:0] m_prev;

  logic [6:0] c_ops [18] = '{7'h03, 7'h07, 7'h0f, 7'h13, 7'h17, 7'h23, 7'h27, 7'h33, 7'h37,
                             7'h43, 7'h47, 7'h4b, 7'h4f, 7'h53, 7'h63, 7'h67, 7'h6f, 7'h73};
  logic [4:0] c_f5s [6]  = '{5'h00, 5'h14, 5'h18, 5'h1c, 5'h1a, 5'h1e};

  cpu_fetch #(.RESET_VECTOR(c_RESET_VECTOR)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .o_bus_request (o_bus_request),
    .o_bus_address (o_bus_address),
    .i_bus_ready   (i_bus_ready),
    .i_bus_rdata   (i_bus_rdata),
    .i_busy        (i_busy),
    .i_pc_valid    (i_pc_valid),
    .i_pc          (i_pc),
    .o_data        (o_data),
    .o_fault       (o_fault)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Record expected for one instruction, built from the ISA operand rules
  function automatic logic [120:0] model_rec(input logic tag, input logic [31:0] w,
                                             input logic [31:0] pc);
    logic [6:0]  op;
    logic [4:0]  f5;
    bit          r4, has_rs1, has_rs2, has_rd, fp_rd, fp_rs1, fp_rs2;
    logic [5:0]  rs1, rs2, rs3, rd;
    logic [31:0] pc4;
    op      = w[6:0];
    f5      = w[31:27];
    r4      = op inside {7'h43, 7'h47, 7'h4b, 7'h4f};
    has_rs1 = !(op inside {7'h37, 7'h17, 7'h6f});
    has_rs2 = op inside {7'h33, 7'h53, 7'h23, 7'h27, 7'h63, 7'h43, 7'h47, 7'h4b, 7'h4f};
    has_rd  = !(op inside {7'h23, 7'h27, 7'h63});
    fp_rd   = (op == 7'h07) || r4 || (op == 7'h53 && !(f5 inside {5'h14, 5'h18, 5'h1c}));
    fp_rs1  = r4 || (op == 7'h53 && !(f5 inside {5'h1a, 5'h1e}));
    fp_rs2  = (op == 7'h27) || r4 || (op == 7'h53);
    rs1 = has_rs1 ? {fp_rs1, w[19:15]} : 6'd0;
    rs2 = has_rs2 ? {fp_rs2, w[24:20]} : 6'd0;
    rs3 = r4      ? {1'b1,   w[31:27]} : 6'd0;
    rd  = has_rd  ? {fp_rd,  w[11:7]}  : 6'd0;
    pc4 = pc + 32'd4;
    return {tag, w, pc, rs1, rs2, rs3, rd, pc4};
  endfunction

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (o_bus_request) begin
        ok = 1'b1;
        break;
      end
      @(negedge i_clock);
    end
    if (!ok) chk("req_timeout", o_bus_request, 1);
  endtask

  // Serve one fetch: answer after `delay` cycles, keep decode busy for hold-1 cycles
  task automatic fetch_one(input logic [31:0] word, input int delay, input int hold,
                           input bit stray);
    bit           ok;
    int           n;
    logic [120:0] exp;
    wait_req(ok);
    if (!ok) return;
    chk("req_addr", o_bus_address, m_pc);
    for (int d = 0; d < delay; d++) begin
      @(negedge i_clock);
      i_pc_valid = 1'b0;
      if (stray && d == 0 && delay > 1) begin
        i_pc_valid = 1'b1;
        i_pc       = $urandom;
      end
    end
    i_pc_valid = 1'b0;
    chk("addr_stable", {o_bus_request, o_bus_address}, {1'b1, m_pc});
    i_bus_ready = 1'b1;
    i_bus_rdata = word;
    i_busy      = 1'b1;
    @(negedge i_clock);
    i_bus_ready = 1'b0;
    i_bus_rdata = $urandom;
    chk("req_drop", o_bus_request, 0);
    n = (hold < 1) ? 1 : hold;
    for (int i = 0; i < n; i++) begin
      chk("hold_data", {o_bus_request, o_data}, {1'b0, m_prev});
      if (i == n - 1) i_busy = 1'b0;
      @(negedge i_clock);
    end
    i_busy = 1'b1;
    m_tag  = ~m_tag;
    exp    = model_rec(m_tag, word, m_pc);
    chk("record", o_data, exp);
    m_prev = exp;
    if (word[1:0] != 2'b11) begin
      chk("illegal_fault", {o_fault, o_bus_request}, 2'b10);
    end else if (word[6:0] inside {7'h63, 7'h67, 7'h6f, 7'h73, 7'h0f}) begin
      chk("ctl_stop", {o_fault, o_bus_request}, 2'b00);
    end else begin
      m_pc = m_pc + 32'd4;
      chk("next_req", {o_fault, o_bus_request, o_bus_address}, {1'b0, 1'b1, m_pc});
    end
  endtask

  task automatic give_pc(input logic [31:0] pc, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(negedge i_clock);
      chk("wait_pc_noreq", o_bus_request, 0);
    end
    i_pc_valid = 1'b1;
    i_pc       = pc;
    @(negedge i_clock);
    i_pc_valid = 1'b0;
    if (pc[1:0] != 2'b00) begin
      chk("pc_fault", {o_fault, o_bus_request}, 2'b10);
    end else begin
      m_pc = pc;
      chk("redirect_req", {o_bus_request, o_bus_address}, {1'b1, pc});
    end
  endtask

  task automatic check_halted(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge i_clock);
      chk("halt_idle", {o_fault, o_bus_request}, 2'b10);
    end
  endtask

  // Asynchronous reset between clock edges, released on a falling edge
  task automatic async_reset();
    #2 i_reset = 1'b0;
    #1;
    chk("rst_data", o_data, 0);
    chk("rst_ctl", {o_fault, o_bus_request}, 2'b00);
    @(negedge i_clock);
    i_reset = 1'b1;
    m_pc    = c_RESET_VECTOR;
    m_tag   = 1'b0;
    m_prev  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [6:0]  op;
    bit          ok;
    i_reset     = 1'b0;
    i_bus_ready = 1'b0;
    i_bus_rdata = 32'd0;
    i_busy      = 1'b1;
    i_pc_valid  = 1'b0;
    i_pc        = 32'd0;
    m_pc        = c_RESET_VECTOR;
    m_tag       = 1'b0;
    m_prev      = '0;
    repeat (2) @(negedge i_clock);
    chk("reset_data", o_data, 0);
    chk("reset_ctl", {o_fault, o_bus_request}, 2'b00);
    i_reset = 1'b1;

    // Directed sequence
    fetch_one(32'h0050_0093, 2, 0, 0);
    chk("addi_fields", o_data[55:32], {6'h00, 6'h00, 6'h00, 6'h01});
    fetch_one(32'h0020_8033, 1, 6, 0);
    chk("add_fields", o_data[55:32], {6'h01, 6'h02, 6'h00, 6'h00});
    fetch_one(32'h0000_006f, 1, 0, 0);
    give_pc(32'h0000_0100, 3);
    fetch_one(32'h0010_7053, 1, 0, 0);
    chk("fadd_fields", o_data[55:32], {6'h20, 6'h21, 6'h00, 6'h20});
    fetch_one(32'hc000_1553, 2, 2, 0);
    chk("fcvt_fields", {o_data[55:50], o_data[37:32]}, {6'h20, 6'h0a});

    // PC wrap at the top of the address space
    fetch_one(32'h0000_006f, 1, 0, 0);
    give_pc(32'hffff_fffc, 1);
    fetch_one(32'h0000_0013, 1, 0, 0);
    chk("wrap_pc4", o_data[31:0], 32'h0000_0000);

    // Random instruction stream with random latency, stalls and stray redirects
    for (int k = 0; k < 40; k++) begin
      w  = $urandom;
      op = c_ops[$urandom_range(0, 17)];
      w[6:0] = op;
      if (op == 7'h53 && $urandom_range(0, 1) == 1) w[31:27] = c_f5s[$urandom_range(0, 5)];
      fetch_one(w, $urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1);
      if (op inside {7'h63, 7'h67, 7'h6f, 7'h73, 7'h0f})
        give_pc($urandom & 32'hffff_fffc, $urandom_range(0, 3));
    end

    // Misaligned redirect halts the stage
    fetch_one(32'h0000_0067, 1, 0, 0);
    give_pc(32'h0000_0102, 2);
    check_halted(4);
    @(negedge i_clock);
    async_reset();

    // Illegal encoding is emitted, then halts
    fetch_one(32'h0000_0013, 2, 0, 0);
    fetch_one(32'h1234_5671, 1, 1, 0);
    check_halted(4);
    @(negedge i_clock);
    async_reset();

    // Reset while a bus read is outstanding
    wait_req(ok);
    @(negedge i_clock);
    chk("mid_wait_req", o_bus_request, 1);
    async_reset();
    fetch_one(32'h0000_0013, 1, 0, 0);
    chk("post_reset_pc", o_data[87:56], c_RESET_VECTOR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
